cpu_state_dumper: RTL
=====================

Name: cpu_state_dumper

Overview:
Hardware state-dump engine for the 5-stage MIPS lab CPU. On a start pulse it reads out the register file, then the low words of data memory, through dedicated read ports and streams each word on a valid/ready output with an identifying tag. It gives the CPU a self-contained readout path for post-run checking, so board builds can use it instead of simulator-only hierarchical peeks. While a dump is in progress it raises a hold request so the CPU state stays frozen.

Parameters:
NUM_REGS, 32, register-file entries dumped (indices 0..NUM_REGS-1); legal range 1..32
DM_WORDS, 16, data-memory words dumped (DM[0..DM_WORDS-1]); legal range 1..128
DATA_W, 32, word width
DM_ADDR_W, 7, data-memory word-address width

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  synchronous, active-high reset
start  in  1  dump request pulse; sampled only in IDLE
reg_raddr  out  5  register-file read address; the read is combinational
reg_rdata  in  DATA_W  REG[reg_raddr]
dm_raddr  out  DM_ADDR_W  data-memory word read address; the read is combinational
dm_rdata  in  DATA_W  DM[dm_raddr]
cpu_hold  out  1  stall request to the CPU; equals busy
busy  out  1  dump in progress (any state other than IDLE)
out_valid  out  1  stream word valid
out_ready  in  1  sink accepts the word
out_data  out  DATA_W  dumped word
out_tag  out  8  bit 7: 0 = register, 1 = DM; bits 6:0 = index
out_last  out  1  high with the final word of the dump
done  out  1  one-cycle pulse after the last handshake

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state IDLE; out_valid, out_last, done, busy and cpu_hold = 0; out_data and out_tag = 0; index counter = 0.
- Reset mid-dump aborts immediately. No further words are sent and done does not pulse.
- States: IDLE, REG_LOAD, REG_SEND, DM_LOAD, DM_SEND, DONE.
- IDLE: if start=1, clear idx and go to REG_LOAD. start is ignored in every other state.
- REG_LOAD (1 cycle): reg_raddr = idx. Capture out_data <= reg_rdata and out_tag <= {1'b0, idx[6:0]}, set out_valid <= 1, go to REG_SEND.
- REG_SEND: hold out_data, out_tag and out_valid stable until out_valid && out_ready.
  - On the handshake: out_valid <= 0.
  - If idx == NUM_REGS-1: clear idx and go to DM_LOAD.
  - Otherwise: idx++ and go to REG_LOAD.
- DM_LOAD and DM_SEND mirror the register phase, using dm_raddr and dm_rdata with tag bit 7 = 1.
  - out_last <= 1 is loaded together with index DM_WORDS-1.
  - On the handshake of the last DM word, go to DONE.
- DONE (1 cycle): done = 1, out_last cleared, then go to IDLE. busy drops in the cycle after DONE.
- reg_raddr and dm_raddr are driven from idx in every state; the values outside the LOAD states don't matter.
- Throughput: exactly 1 word per 2 cycles when out_ready is held high. Each stalled cycle (out_ready=0) adds one cycle.
- Latency, with start sampled in cycle 0:
  - REG_LOAD in cycle 1; first out_valid in cycle 2.
  - With the defaults and out_ready=1: last handshake in cycle 96, done in cycle 97.
- out_ready may be asserted with or without out_valid. It has no effect while out_valid=0.
- out_valid never deasserts without a handshake, except on reset.
- Data is sampled exactly once per word, in its LOAD cycle. The CPU is required to honour cpu_hold for the snapshot to be consistent.

Test Plan:
- Reset, then start with REG[1]=25, REG[2]=25, others 0, DM[0]=9, DM[1]=3, DM[2]=15, DM[3]=2, out_ready=1 -> required stream:
  - word 0: tag 0x00, data 0
  - words 1 and 2: tags 0x01 and 0x02, data 0x19
  - DM words: tags 0x80, 0x81, 0x82, 0x83 with data 9, 3, 0xF, 2
  - 48 words total, out_last only on tag 0x8F, done in cycle 97.
- Backpressure: out_ready=0 for 5 cycles while tag 0x01 is presented -> out_data stays 0x19 and tag 0x01 for all 5 cycles; no word is lost or duplicated; done is delayed by exactly 5 cycles.
- start pulses at cycles 10 and 40 during a dump -> both are ignored; exactly 48 words and one done pulse.
- rst asserted while tag 0x85 is presented -> the next cycle has out_valid=0, busy=0 and no done; a fresh start then begins again at tag 0x00.
- Parameters NUM_REGS=4, DM_WORDS=1 -> 5 words (tags 0x00 to 0x03, then 0x80 with out_last=1); done in cycle 11 with ready held high.
- cpu_hold equals busy in every cycle: high from cycle 1 through DONE, low in IDLE.

Source files
------------

// File: rtl/cpu_state_dumper.sv
// State-dump engine: streams the register file, then the low data-memory words,
// on a valid/ready port tagged with source and index, holding the CPU while busy.
module cpu_state_dumper #(
  parameter int NUM_REGS  = 32,
  parameter int DM_WORDS  = 16,
  parameter int DATA_W    = 32,
  parameter int DM_ADDR_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [4:0]           reg_raddr,
  input  logic [DATA_W-1:0]    reg_rdata,
  output logic [DM_ADDR_W-1:0] dm_raddr,
  input  logic [DATA_W-1:0]    dm_rdata,
  output logic                 cpu_hold,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [7:0]           out_tag,
  output logic                 out_last,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE,
    REG_LOAD,
    REG_SEND,
    DM_LOAD,
    DM_SEND,
    DONE
  } state_t;

  state_t     state, nxt;
  logic [6:0] idx;
  logic       hs;
  logic       reg_last;
  logic       dm_last;

  assign hs       = out_valid && out_ready;
  assign reg_last = (idx == 7'(NUM_REGS - 1));
  assign dm_last  = (idx == 7'(DM_WORDS - 1));

  assign reg_raddr = idx[4:0];
  assign dm_raddr  = DM_ADDR_W'(idx);
  assign busy      = (state != IDLE);
  assign cpu_hold  = busy;
  assign done      = (state == DONE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (start) nxt = REG_LOAD;
      REG_LOAD: nxt = REG_SEND;
      REG_SEND: if (hs) nxt = reg_last ? DM_LOAD : REG_LOAD;
      DM_LOAD:  nxt = DM_SEND;
      DM_SEND:  if (hs) nxt = dm_last ? DONE : DM_LOAD;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // Datapath registers ride along with the state register; each word is
  // sampled once, in its LOAD cycle, and held until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (start) idx <= '0;
        REG_LOAD: begin
          out_data  <= reg_rdata;
          out_tag   <= {1'b0, idx};
          out_valid <= 1'b1;
        end
        REG_SEND: if (hs) begin
          out_valid <= 1'b0;
          idx       <= reg_last ? '0 : idx + 7'd1;
        end
        DM_LOAD: begin
          out_data  <= dm_rdata;
          out_tag   <= {1'b1, idx};
          out_valid <= 1'b1;
          out_last  <= dm_last;
        end
        DM_SEND: if (hs) begin
          out_valid <= 1'b0;
          idx       <= dm_last ? '0 : idx + 7'd1;
        end
        DONE: begin
          out_last <= 1'b0;
          idx      <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
